pulse_train_gen: RTL
====================

// Module: pulse_train_gen
// PURPOSE
//   Generates a programmable train of N rectangular pulses on sig: each pulse is high_cycles
//   high followed by low_cycles low. Source side of the edge-counting activity detector.
//   Drives test/stimulus lines, LED blink codes and self-test loopbacks into the detector.
//   Start/busy/done control; configuration is latched at start.
// PARAMETERS
//   CNT_W  16  width of high_cycles/low_cycles and internal phase counter
//   NUM_W   8  width of num_pulses and pulses_sent
// PORTS
//   clk          in   1      system clock; all logic on rising edge
//   rst          in   1      synchronous, active-high reset
//   start        in   1      request new train; accepted only when busy=0
//   abort        in   1      terminate train in progress
//   high_cycles  in   CNT_W  high phase length in clk cycles (0 treated as 1)
//   low_cycles   in   CNT_W  low phase length in clk cycles (0 treated as 1)
//   num_pulses   in   NUM_W  pulses per train (0 = empty train)
//   sig          out  1      generated pulse output (registered)
//   busy         out  1      train in progress
//   done         out  1      one-cycle strobe, train completed normally
//   pulses_sent  out  NUM_W  falling edges emitted in current/last train
// BEHAVIOUR
//   - Reset: sig=0, busy=0, done=0, pulses_sent=0, state IDLE; effective the cycle after rst
//     is sampled, including mid-train. No partial pulse completes after reset.
//   - States: IDLE, HIGH, LOW. All outputs registered. Phase counter is CNT_W bits.
//   - Timing (start sampled high in cycle 0, with H/L/N the latched values):
//     busy=1 in cycles 1..N*(H+L); sig=1 in cycles 1..H, 0 in H+1..H+L, and so on.
//     done=1, busy=0 in cycle N*(H+L)+1. The final low phase is always emitted, so
//     back-to-back trains keep at least L low cycles between pulses.
//   - IDLE: start & ~abort -> latch high_cycles/low_cycles/num_pulses; clear pulses_sent; go HIGH.
//     If num_pulses==0: no sig activity, busy stays 0, done=1 in cycle 1.
//   - HIGH: after H cycles -> LOW. pulses_sent increments in the same cycle sig falls.
//   - LOW: after L cycles -> HIGH if pulses_sent<N, else IDLE with done strobe.
//   - Input changes while busy have no effect. start while busy is ignored, not queued.
//   - start in the done cycle (busy=0) is accepted; the next train begins with no gap beyond L.
//   - abort while busy: next cycle sig=0, busy=0, state IDLE. done is not asserted;
//     pulses_sent holds its value. Abort in IDLE is a no-op.
//   - Simultaneous start and abort in IDLE: abort wins and start is dropped.
//   - Max values: H=L=2^CNT_W-1 and N=2^NUM_W-1 are legal. No counter overflow;
//     pulses_sent never exceeds N.
//   - done is never asserted with busy=1. sig=1 only while busy=1.
// TESTING
//   1. H=2,L=3,N=4: start at cycle 0 -> sig high cycles 1-2,6-7,11-12,16-17. done at cycle 21,
//      pulses_sent=4. A looped-back falling-edge counter reads 4.
//   2. N=0: start -> done=1 at cycle 1, busy and sig stay 0, pulses_sent=0.
//   3. H=0,L=0,N=3: sig=1,0,1,0,1,0 in cycles 1-6; done at cycle 7.
//   4. H=4,L=4,N=10: abort in cycle 13 -> sig=0, busy=0 in cycle 14, no done,
//      pulses_sent=2. Then start+abort together -> no train.
//   5. H=1,L=1,N=2: start again in cycle 3 (ignored). start in done cycle 5 -> new train
//      with sig=1 in cycle 6. Config changed mid-train has no effect.
//   6. H=3,L=3,N=5: rst in cycle 8 -> all outputs 0 in cycle 9; a fresh start runs
//      a correct full train.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: emits num_pulses rectangular pulses
// (high_cycles high, then low_cycles low) on sig, with start/busy/done control.
// Configuration is captured when a train starts, and every output is registered.
module pulse_train_gen #(
  parameter int CNT_W = 16,
  parameter int NUM_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] high_cycles,
  input  logic [CNT_W-1:0] low_cycles,
  input  logic [NUM_W-1:0] num_pulses,
  output logic             sig,
  output logic             busy,
  output logic             done,
  output logic [NUM_W-1:0] pulses_sent
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    LOW  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [NUM_W-1:0] NUM_ONE = NUM_W'(1);

  state_t           state_reg, state_next;
  // The phase counter holds the 1-based index of the current cycle within the phase.
  // It only has to reach the latched length, which always fits in CNT_W bits.
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] high_reg, high_next;
  logic [CNT_W-1:0] low_reg, low_next;
  logic [NUM_W-1:0] num_reg, num_next;
  logic [NUM_W-1:0] sent_reg, sent_next;
  logic             sig_reg, sig_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  // Next-state and next-output logic. Each cycle starts from "hold everything, no done".
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    high_next  = high_reg;
    low_next   = low_reg;
    num_next   = num_reg;
    sent_next  = sent_reg;
    sig_next   = sig_reg;
    busy_next  = busy_reg;
    done_next  = 1'b0;

    case (state_reg)
      IDLE: begin
        sig_next  = 1'b0;
        busy_next = 1'b0;
        // abort has priority, so start+abort together starts nothing.
        if (start && !abort) begin
          sent_next = '0;
          if (num_pulses == '0) begin
            // An empty train completes at once, with no sig activity and no busy.
            done_next = 1'b1;
          end else begin
            // Zero-length phases are stretched to one cycle when they are latched.
            high_next  = (high_cycles == '0) ? CNT_ONE : high_cycles;
            low_next   = (low_cycles == '0) ? CNT_ONE : low_cycles;
            num_next   = num_pulses;
            cnt_next   = CNT_ONE;
            state_next = HIGH;
            sig_next   = 1'b1;
            busy_next  = 1'b1;
          end
        end
      end

      HIGH: begin
        if (abort) begin
          state_next = IDLE;
          sig_next   = 1'b0;
          busy_next  = 1'b0;
        end else if (cnt_reg == high_reg) begin
          // The falling edge and its count land in the same cycle.
          state_next = LOW;
          sig_next   = 1'b0;
          sent_next  = sent_reg + NUM_ONE;
          cnt_next   = CNT_ONE;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      LOW: begin
        if (abort) begin
          state_next = IDLE;
          sig_next   = 1'b0;
          busy_next  = 1'b0;
        end else if (cnt_reg == low_reg) begin
          // The final low phase is always played out before done fires.
          if (sent_reg < num_reg) begin
            state_next = HIGH;
            sig_next   = 1'b1;
            cnt_next   = CNT_ONE;
          end else begin
            state_next = IDLE;
            busy_next  = 1'b0;
            done_next  = 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end

      default: begin
        state_next = IDLE;
        sig_next   = 1'b0;
        busy_next  = 1'b0;
      end
    endcase
  end

  // State, latched configuration and the registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      high_reg  <= '0;
      low_reg   <= '0;
      num_reg   <= '0;
      sent_reg  <= '0;
      sig_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      high_reg  <= high_next;
      low_reg   <= low_next;
      num_reg   <= num_next;
      sent_reg  <= sent_next;
      sig_reg   <= sig_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
    end
  end

  assign sig         = sig_reg;
  assign busy        = busy_reg;
  assign done        = done_reg;
  assign pulses_sent = sent_reg;

endmodule
